booth_seq_mult: RTL and testbench
=================================

Name: booth_seq_mult

Overview:
- Sequential radix-4 Booth multiplier controller for the FMAC mantissa path.
- Consumes one Booth digit per clock and steps a single shared Booth encoder across the multiplier.
- Selects, negates and accumulates partial products into a 2*WIDTH product register.
- Uses a start/done handshake toward the FMAC top-level sequencer.

Parameters:
- WIDTH, 24, operand width in bits. Operands are two's-complement signed. WIDTH must be even and at least 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a multiply. Sampled only when ready=1.
- a  input  WIDTH  multiplicand, signed. Captured when start is accepted.
- b  input  WIDTH  multiplier, signed. Captured when start is accepted.
- ready  output  1  high only in IDLE. Block accepts start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse. Product is valid.
- product  output  2*WIDTH  signed result. Held from done until the next accepted start.
- digits_used  output  $clog2(WIDTH/2+1)  number of Booth digits processed for the last result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, digits_used=0, all internal registers 0.
- States:
  - IDLE: ready=1. On start=1, capture the operands and go to RUN.
  - RUN: busy=1. Process one digit per cycle.
  - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- Operand capture on start acceptance:
  - mreg (WIDTH+1 bits) = {b, 1'b0}.
  - mcand (2*WIDTH bits) = sign-extended a.
  - acc = 0, cnt = 0.
- Each RUN edge:
  - triple = mreg[2:0], encoded as {one, two, neg}:
    - 000 or 111 -> 000, +0
    - 001 or 010 -> 100, +1x
    - 011 -> 010, +2x
    - 100 -> 011, -2x
    - 101 or 110 -> 101, -1x
  - pp = one ? mcand : two ? mcand<<1 : 0. If neg, pp = -pp (two's complement, 2*WIDTH wide).
  - acc <= acc + pp, modulo 2^(2*WIDTH).
  - mcand <= mcand << 2.
  - mreg <= arithmetic shift right by 2.
  - cnt <= cnt + 1.
- Leaving RUN: when cnt reaches WIDTH/2, go to DONE. On the transition, product <= final acc and digits_used <= cnt.
- Latency: start accepted at edge E0. Digits are processed at edges E1..E(WIDTH/2). done is high in the cycle after E(WIDTH/2). ready returns the cycle after that.
- Start-to-start throughput: WIDTH/2 + 2 cycles.
- start asserted while not in IDLE is ignored. It is not queued.
- start held high continuously: a new operation is accepted on every IDLE cycle.
- a and b are don't-care outside the acceptance edge.
- rst mid-RUN or in DONE: return to IDLE on the next edge and clear product and done. No partial result is visible.
- Boundary case: the most negative operands, e.g. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), must be exact with no overflow.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - After each RUN digit, if all WIDTH+1 bits of the post-shift mreg are equal (all 0 or all 1), every remaining digit is zero.
  - In that case go to DONE immediately, with product = acc.
  - digits_used reports the actual count, between 1 and WIDTH/2.
  - At least one digit is always processed.
- Undefined:
  - Always WIDTH/2 digits.
  - digits_used is always WIDTH/2.
  - Latency is fixed.

Test Plan (WIDTH=8):
- rst held 2 cycles, then released -> ready=1, busy=0, done=0, product=0.
- a=3, b=5, start 1 cycle -> busy for 4 cycles, done pulse in cycle 5 after acceptance, product=15.
- a=-7, b=6 -> product=-42 (16'hFFD6); a=-128, b=-128 -> product=16384 (16'h4000); a=127, b=-128 -> product=-16256.
- start reasserted during RUN with a=1, b=1 -> ignored; the original result is delivered. A back-to-back start on the IDLE cycle is accepted.
- rst asserted in the 2nd RUN cycle of a=9, b=9 -> IDLE next cycle, product=0, no done pulse. A following 9*9 gives 81.
- With BOOTH_EARLY_TERM_EN:
  - b=0 -> done after 1 digit, digits_used=1, product=0.
  - b=-1, a=5 -> digits_used=1, product=-5.
  - b=3, a=2 -> digits_used=2, product=6.
  - Without the macro, all three cases give digits_used=4 and the same products.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, start/done handshake.
// Optional macro BOOTH_EARLY_TERM_EN stops as soon as every remaining digit is zero.
module booth_seq_mult #(
   parameter int WIDTH = 24
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [WIDTH-1:0]                 a,
   input  logic [WIDTH-1:0]                 b,
   output logic                             ready,
   output logic                             busy,
   output logic                             done,
   output logic [2*WIDTH-1:0]               product,
   output logic [$clog2(WIDTH/2+1)-1:0]     digits_used
);
   localparam int NDIG = WIDTH / 2;
   localparam int CW   = $clog2(WIDTH/2+1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, next_state;
   logic [WIDTH:0]       mreg, mreg_nxt;
   logic [2*WIDTH-1:0]   mcand, acc, acc_nxt, pp_mag, pp;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 one, two, neg, last;

   // Booth digit decode of the current overlapping triple.
   always_comb begin
      one = 1'b0;
      two = 1'b0;
      neg = 1'b0;
      case (mreg[2:0])
         3'b001, 3'b010: one = 1'b1;
         3'b011:         two = 1'b1;
         3'b100: begin
            two = 1'b1;
            neg = 1'b1;
         end
         3'b101, 3'b110: begin
            one = 1'b1;
            neg = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      pp_mag   = one ? mcand : (two ? (mcand << 1) : '0);
      pp       = neg ? (~pp_mag + 1'b1) : pp_mag;
      acc_nxt  = acc + pp;
      mreg_nxt = {mreg[WIDTH], mreg[WIDTH], mreg[WIDTH:2]};
      cnt_nxt  = cnt + 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
      last     = (cnt_nxt == CW'(NDIG)) || (mreg_nxt == '0) || (mreg_nxt == '1);
`else
      last     = (cnt_nxt == CW'(NDIG));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         mreg        <= '0;
         mcand       <= '0;
         acc         <= '0;
         cnt         <= '0;
         product     <= '0;
         digits_used <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               mreg  <= {b, 1'b0};
               mcand <= {{WIDTH{a[WIDTH-1]}}, a};
               acc   <= '0;
               cnt   <= '0;
            end
            RUN: begin
               acc   <= acc_nxt;
               mcand <= mcand << 2;
               mreg  <= mreg_nxt;
               cnt   <= cnt_nxt;
               if (last) begin
                  product     <= acc_nxt;
                  digits_used <= cnt_nxt;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult at WIDTH=8; reference is plain signed multiplication.
module tb_booth_seq_mult;
   localparam int W    = 8;
   localparam int NDIG = W / 2;
   localparam int CW   = $clog2(W/2+1);

   logic            clk = 1'b0;
   logic            rst, start;
   logic [W-1:0]    a, b;
   logic            ready, busy, done;
   logic [2*W-1:0]  product;
   logic [CW-1:0]   digits_used;

   typedef struct {
      logic [2*W-1:0] prod;
      int             digs;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done),
      .product(product), .digits_used(digits_used)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Digits needed: first k>=1 where the multiplier remaining after k digits is all sign bits.
   function automatic int exp_digits(input int sb);
`ifdef BOOTH_EARLY_TERM_EN
      for (int k = 1; k <= NDIG; k++) begin
         int v;
         v = (2 * sb) >>> (2 * k);
         if (v == 0 || v == -1) return k;
      end
      return NDIG;
`else
      return NDIG + 0 * sb;
`endif
   endfunction

   function automatic exp_t model(input int sa, input int sb);
      exp_t e;
      int   p;
      p      = sa * sb;
      e.prod = p[2*W-1:0];
      e.digs = exp_digits(sb);
      return e;
   endfunction

   // Monitor: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("product", longint'($signed(product)), longint'($signed(e.prod)));
            check("digits_used", digits_used, e.digs);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) check("ready_timeout", 0, 1);
   endtask

   // Returns number of edges after acceptance until done is observed (0 on timeout).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!done && n < 100);
      if (!done) begin
         check("done_timeout", 0, 1);
         n = 0;
      end
   endtask

   task automatic do_op(input int sa, input int sb);
      int n;
      exp_t e;
      wait_ready();
      a     = sa[W-1:0];
      b     = sb[W-1:0];
      start = 1'b1;
      e     = model(sa, sb);
      exp_q.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(n);
      check("latency", n, e.digs);
   endtask

   initial begin
      int n;
      int sa, sb;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_digits", digits_used, 0);

      // Basic case with busy window check.
      wait_ready();
      a = 8'd3; b = 8'd5; start = 1'b1;
      exp_q.push_back(model(3, 5));
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      for (int i = 0; i < NDIG; i++) begin
         @(negedge clk);
         if (busy) n++;
      end
      check("busy_cycles", n, exp_digits(5));
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("ready_after_done", ready, 1);

      do_op(-7, 6);
      do_op(-128, -128);
      do_op(127, -128);
      do_op(-128, 127);
      do_op(0, 0);
      do_op(5, -1);
      do_op(2, 3);
      do_op(-1, -1);

      // start held through RUN with different operands, then back-to-back acceptance.
      wait_ready();
      a = 8'd3; b = 8'd5; start = 1'b1;
      exp_q.push_back(model(3, 5));
      @(posedge clk);
      #1 a = 8'd1; b = 8'd1;
      wait_done(n);
      check("held_start_latency", n, exp_digits(5));
      a = 8'd6; b = 8'd7;
      exp_q.push_back(model(6, 7));
      @(posedge clk);
      @(negedge clk);
      check("b2b_idle_ready", ready, 1);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b_accepted", busy, 1);
      wait_done(n);

      // Reset in the second RUN cycle aborts without a done pulse.
      wait_ready();
      a = 8'd9; b = 8'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      check("abort_product", product, 0);
      check("abort_done", done, 0);
      do_op(9, 9);

      for (int i = 0; i < 40; i++) begin
         sa = $urandom_range(0, 255);
         sb = $urandom_range(0, 255);
         if (sa > 127) sa -= 256;
         if (sb > 127) sb -= 256;
         do_op(sa, sb);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
